// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: register width, forwarding mux encodings and shadow-stage records
package pipe_hazard_ctrl_pkg;
    localparam int RA_W = 5;
    localparam logic [1:0] FWD_IDEX  = 2'd0;
    localparam logic [1:0] FWD_MEMWB = 2'd1;
    localparam logic [1:0] FWD_EXMEM = 2'd2;
    typedef logic [RA_W-1:0] reg_t;
    // ua/ub record whether a live (non-bubble) ID/EX instruction really reads rs/rt
    typedef struct packed {
        reg_t rs;
        reg_t rt;
        reg_t dst;
        logic rw;
        logic mr;
        logic ua;
        logic ub;
    } idex_t;
    typedef struct packed {
        reg_t dst;
        logic rw;
        logic mr;
    } exmem_t;
    typedef struct packed {
        reg_t dst;
        logic rw;
    } memwb_t;
    function automatic logic writes(logic rw, reg_t dst, reg_t r);
        return rw && dst == r && r != '0;
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID decode and EX branch inputs in, mux selects/enables/counters out
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
    import pipe_hazard_ctrl_pkg::*;
    reg_t             id_rs;
    reg_t             id_rt;
    reg_t             id_dst;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             ex_br_taken;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             id_byp_a;
    logic             id_byp_b;
    logic             ctrl_bubble;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    modport master (
        output id_rs, id_rt, id_dst, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, ex_br_taken,
        input  fwd_a_sel, fwd_b_sel, id_byp_a, id_byp_b, ctrl_bubble, pc_write, ifid_write, ifid_flush,
               stall_cnt, flush_cnt
    );
    modport slave (
        input  id_rs, id_rt, id_dst, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, ex_br_taken,
        output fwd_a_sel, fwd_b_sel, id_byp_a, id_byp_b, ctrl_bubble, pc_write, ifid_write, ifid_flush,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with synchronous clear
module sat_counter #(parameter int CNT_W = 16) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= cnt_d;
    assign cnt = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding/bypass selects, load-use stall and branch flush from a shadow of the back-end pipe
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(parameter int CNT_W = 16) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);
    idex_t  idex_q, idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;
    logic   load_use, bubble;
    always_comb begin
        load_use = idex_q.mr && ((bus.id_uses_rs && writes(idex_q.rw, idex_q.dst, bus.id_rs)) ||
                                 (bus.id_uses_rt && writes(idex_q.rw, idex_q.dst, bus.id_rt)));
        bubble = reset || bus.ex_br_taken || load_use;
        bus.ctrl_bubble = bubble;
        bus.pc_write = !reset && (bus.ex_br_taken || !load_use);
        bus.ifid_write = !reset && (bus.ex_br_taken || !load_use);
        bus.ifid_flush = reset || bus.ex_br_taken;
        // the youngest producer (EX/MEM) wins over MEM/WB
        bus.fwd_a_sel = reset ? FWD_IDEX :
                        (writes(exmem_q.rw, exmem_q.dst, idex_q.rs) && !exmem_q.mr) ? FWD_EXMEM :
                        writes(memwb_q.rw, memwb_q.dst, idex_q.rs) ? FWD_MEMWB : FWD_IDEX;
        bus.fwd_b_sel = reset ? FWD_IDEX :
                        (writes(exmem_q.rw, exmem_q.dst, idex_q.rt) && !exmem_q.mr) ? FWD_EXMEM :
                        writes(memwb_q.rw, memwb_q.dst, idex_q.rt) ? FWD_MEMWB : FWD_IDEX;
        bus.id_byp_a = !reset && writes(memwb_q.rw, memwb_q.dst, bus.id_rs);
        bus.id_byp_b = !reset && writes(memwb_q.rw, memwb_q.dst, bus.id_rt);
        idex_d = '{rs: bus.id_rs, rt: bus.id_rt, dst: bus.id_dst,
                   rw: bus.id_reg_write && !bubble, mr: bus.id_mem_read && !bubble,
                   ua: bus.id_uses_rs && !bubble, ub: bus.id_uses_rt && !bubble};
        exmem_d = '{dst: idex_q.dst, rw: idex_q.rw, mr: idex_q.mr};
        memwb_d = '{dst: exmem_q.dst, rw: exmem_q.rw};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end
    // a load in EX/MEM feeding a live consumer in ID/EX must have been stalled away
    always_ff @(posedge clk)
        if (!reset)
            assert (!(exmem_q.mr && ((idex_q.ua && writes(exmem_q.rw, exmem_q.dst, idex_q.rs)) ||
                                     (idex_q.ub && writes(exmem_q.rw, exmem_q.dst, idex_q.rt)))));
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .clr(reset), .inc(load_use && !bus.ex_br_taken), .cnt(bus.stall_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(clk), .clr(reset), .inc(bus.ex_br_taken), .cnt(bus.flush_cnt)
    );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed hazard scenarios plus random traffic against a queue-based pipeline model
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;
    localparam int CNT_W = 4;
    localparam int CMAX = (1 << CNT_W) - 1;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct { int rs; int rt; int dst; bit rw; bit mr; } rec_t;
    typedef struct { int pc; int ifw; int fl; int bub; int fa; int fb; int ba; int bb; bit lu; } exp_t;
    rec_t pipe[$];
    rec_t zrec = '{default: 0};
    int m_stall = 0, m_flush = 0;
    int errors = 0, checks = 0;
    bit chk_en = 0;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    function automatic bit wr(rec_t e, int r);
        return e.rw && e.dst == r && r != 0;
    endfunction
    // pipe[0]=ID/EX, pipe[1]=EX/MEM, pipe[2]=MEM/WB
    function automatic int fsel(int r);
        if (wr(pipe[1], r) && !pipe[1].mr) return 2;
        if (wr(pipe[2], r)) return 1;
        return 0;
    endfunction
    function automatic exp_t model();
        exp_t e;
        int rs = int'(bus.id_rs);
        int rt = int'(bus.id_rt);
        e.lu = pipe[0].mr && ((bus.id_uses_rs && wr(pipe[0], rs)) || (bus.id_uses_rt && wr(pipe[0], rt)));
        if (reset) begin e.pc = 0; e.ifw = 0; e.fl = 1; e.bub = 1; end
        else if (bus.ex_br_taken) begin e.pc = 1; e.ifw = 1; e.fl = 1; e.bub = 1; end
        else if (e.lu) begin e.pc = 0; e.ifw = 0; e.fl = 0; e.bub = 1; end
        else begin e.pc = 1; e.ifw = 1; e.fl = 0; e.bub = 0; end
        e.fa = reset ? 0 : fsel(pipe[0].rs);
        e.fb = reset ? 0 : fsel(pipe[0].rt);
        e.ba = (!reset && wr(pipe[2], rs)) ? 1 : 0;
        e.bb = (!reset && wr(pipe[2], rt)) ? 1 : 0;
        return e;
    endfunction
    always @(posedge clk) begin
        exp_t e;
        rec_t n;
        e = model();
        if (reset) begin
            pipe = '{zrec, zrec, zrec};
            m_stall = 0;
            m_flush = 0;
        end else begin
            n.rs = int'(bus.id_rs);
            n.rt = int'(bus.id_rt);
            n.dst = int'(bus.id_dst);
            n.rw = bus.id_reg_write && !e.bub;
            n.mr = bus.id_mem_read && !e.bub;
            pipe.push_front(n);
            void'(pipe.pop_back());
            if (e.lu && !bus.ex_br_taken && m_stall < CMAX) m_stall++;
            if (bus.ex_br_taken && m_flush < CMAX) m_flush++;
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            e = model();
            chk("pc_write", int'(bus.pc_write), e.pc);
            chk("ifid_write", int'(bus.ifid_write), e.ifw);
            chk("ifid_flush", int'(bus.ifid_flush), e.fl);
            chk("ctrl_bubble", int'(bus.ctrl_bubble), e.bub);
            chk("fwd_a_sel", int'(bus.fwd_a_sel), e.fa);
            chk("fwd_b_sel", int'(bus.fwd_b_sel), e.fb);
            chk("id_byp_a", int'(bus.id_byp_a), e.ba);
            chk("id_byp_b", int'(bus.id_byp_b), e.bb);
            chk("stall_cnt", int'(bus.stall_cnt), m_stall);
            chk("flush_cnt", int'(bus.flush_cnt), m_flush);
        end
    end
    task automatic drv(input int rs, input int rt, input int urs, input int urt,
                       input int dst, input int rw, input int mr, input int br);
        bus.id_rs = reg_t'(rs);
        bus.id_rt = reg_t'(rt);
        bus.id_uses_rs = (urs != 0);
        bus.id_uses_rt = (urt != 0);
        bus.id_dst = reg_t'(dst);
        bus.id_reg_write = (rw != 0);
        bus.id_mem_read = (mr != 0);
        bus.ex_br_taken = (br != 0);
        #2;
    endtask
    task automatic nop();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        pipe = '{zrec, zrec, zrec};
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nop();
            chk("rst pc_write", int'(bus.pc_write), 0);
            chk("rst ifid_flush", int'(bus.ifid_flush), 1);
            chk("rst ctrl_bubble", int'(bus.ctrl_bubble), 1);
            tick();
            chk_en = 1;
        end
        reset = 1'b0;
        nop();
        chk("post pc_write", int'(bus.pc_write), 1);
        chk("post ifid_write", int'(bus.ifid_write), 1);
        chk("post fwd_a", int'(bus.fwd_a_sel), 0);
        chk("post fwd_b", int'(bus.fwd_b_sel), 0);
        chk("post stall_cnt", int'(bus.stall_cnt), 0);
        chk("post flush_cnt", int'(bus.flush_cnt), 0);
        tick();
        drv(1, 2, 1, 1, 3, 1, 0, 0); tick();
        drv(3, 4, 1, 1, 6, 1, 0, 0); tick();
        nop();
        chk("exmem fwd_a", int'(bus.fwd_a_sel), 2);
        tick();
        drv(1, 2, 1, 1, 3, 1, 0, 0); tick();
        drv(1, 1, 1, 0, 8, 1, 0, 0); tick();
        drv(3, 4, 1, 1, 6, 1, 0, 0); tick();
        nop();
        chk("memwb fwd_a", int'(bus.fwd_a_sel), 1);
        tick();
        drv(1, 2, 1, 1, 0, 1, 0, 0); tick();
        drv(0, 4, 1, 1, 6, 1, 0, 0); tick();
        nop();
        chk("r0 fwd_a", int'(bus.fwd_a_sel), 0);
        tick(); tick(); tick();
        drv(1, 0, 1, 0, 5, 1, 1, 0); tick();
        drv(2, 5, 1, 1, 9, 1, 0, 0);
        chk("lu pc_write", int'(bus.pc_write), 0);
        chk("lu ifid_write", int'(bus.ifid_write), 0);
        chk("lu ctrl_bubble", int'(bus.ctrl_bubble), 1);
        tick();
        drv(2, 5, 1, 1, 9, 1, 0, 0);
        chk("lu once pc_write", int'(bus.pc_write), 1);
        chk("lu stall_cnt", int'(bus.stall_cnt), 1);
        tick();
        nop();
        chk("lu fwd_b", int'(bus.fwd_b_sel), 1);
        tick();
        drv(1, 0, 1, 0, 5, 1, 1, 0); tick();
        drv(2, 5, 1, 1, 9, 1, 0, 1);
        chk("br ifid_flush", int'(bus.ifid_flush), 1);
        chk("br pc_write", int'(bus.pc_write), 1);
        tick();
        nop();
        chk("br stall_cnt", int'(bus.stall_cnt), 1);
        chk("br flush_cnt", int'(bus.flush_cnt), 1);
        tick();
        drv(1, 2, 1, 1, 7, 1, 0, 0); tick();
        drv(1, 2, 1, 1, 7, 1, 0, 0); tick();
        drv(7, 2, 1, 1, 10, 1, 0, 0); tick();
        drv(7, 0, 1, 0, 11, 1, 0, 0);
        chk("r7 fwd_a", int'(bus.fwd_a_sel), 2);
        chk("r7 id_byp_a", int'(bus.id_byp_a), 1);
        tick();
        for (int i = 0; i < 20; i++) begin
            drv(1, 0, 1, 0, 5, 1, 1, 0); tick();
            drv(2, 5, 1, 1, 9, 1, 0, 0); tick();
            drv(2, 5, 1, 1, 9, 1, 0, 0); tick();
        end
        nop();
        chk("sat stall_cnt", int'(bus.stall_cnt), 15);
        tick();
        drv(1, 0, 1, 0, 5, 1, 1, 0); tick();
        reset = 1'b1;
        drv(2, 5, 1, 1, 9, 1, 0, 0);
        chk("rst-stall pc_write", int'(bus.pc_write), 0);
        chk("rst-stall ctrl_bubble", int'(bus.ctrl_bubble), 1);
        tick();
        reset = 1'b0;
        nop();
        chk("rst-stall stall_cnt", int'(bus.stall_cnt), 0);
        chk("rst-stall flush_cnt", int'(bus.flush_cnt), 0);
        chk("rst-stall pc_write", int'(bus.pc_write), 1);
        tick();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(63) == 0);
            drv($urandom_range(7), $urandom_range(7), $urandom_range(1), $urandom_range(1),
                $urandom_range(7), $urandom_range(1), ($urandom_range(2) == 0) ? 1 : 0,
                ($urandom_range(7) == 0) ? 1 : 0);
            tick();
        end
        reset = 1'b0;
        nop();
        tick(); tick();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
